decoding_stage_controller: RTL and testbench

//  Top-level sequencer for the PE array. Drives the shared global_stage bus through

---
 rtl/decoding_stage_controller_pkg.sv | 16 +
 rtl/decoding_stage_controller_pe_status_reducer.sv | 30 +++
 rtl/decoding_stage_controller.sv | 154 +++++++++++++++
 tb/tb_decoding_stage_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoding_stage_controller_pkg.sv
// Shared stage-bus encodings for the PE array and its decoding_stage_controller.
// Every PE decodes global_stage against these constants.
package decoding_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef logic [STAGE_WIDTH-1:0] stage_t;

  localparam stage_t STAGE_IDLE                = 3'd0;
  localparam stage_t STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam stage_t STAGE_GROW                = 3'd2;
  localparam stage_t STAGE_MERGE               = 3'd3;
  localparam stage_t STAGE_PEELING             = 3'd4;
  localparam stage_t STAGE_RESULT_VALID        = 3'd5;

endpackage

// File: rtl/decoding_stage_controller_pe_status_reducer.sv
// pe_status_reducer: one-cycle registered reduction of per-PE status vectors
// into busy_any (OR), odd_any (OR) and peel_all (AND).
module pe_status_reducer #(
  parameter int PU_COUNT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PU_COUNT-1:0] pe_busy,
  input  logic [PU_COUNT-1:0] pe_odd,
  input  logic [PU_COUNT-1:0] pe_peeling_complete,
  output logic                busy_any,
  output logic                odd_any,
  output logic                peel_all
);

  // Register the three reductions; this stage is part of the controller's settle budget.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      busy_any <= 1'b0;
      odd_any  <= 1'b0;
      peel_all <= 1'b0;
    end else begin
      busy_any <= |pe_busy;
      odd_any  <= |pe_odd;
      peel_all <= &pe_peeling_complete;
    end
  end

endmodule

// File: rtl/decoding_stage_controller.sv
// decoding_stage_controller: sequences the PE array through load, grow/merge
// iterations and peeling, then holds the result until the consumer accepts it.
// Optional feature macro: DECODE_CYCLE_COUNTER_EN adds the decode_cycles output.
module decoding_stage_controller
  import decoding_stage_controller_pkg::*;
#(
  parameter int PU_COUNT         = 64,
  parameter int GROW_CYCLES      = 2,
  parameter int STATUS_LATENCY   = 3,
  parameter int MAX_ITERATIONS   = 16,
  parameter int MAX_MERGE_CYCLES = 255,
  parameter int ITER_WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   meas_valid,
  output logic                   meas_ready,
  input  logic [PU_COUNT-1:0]    pe_busy,
  input  logic [PU_COUNT-1:0]    pe_odd,
  input  logic [PU_COUNT-1:0]    pe_peeling_complete,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   decode_error
`ifdef DECODE_CYCLE_COUNTER_EN
  ,
  output logic [31:0]            decode_cycles
`endif
);

  // State values equal the stage encodings, so the state register drives the bus directly.
  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE   = STAGE_IDLE,
    ST_LOAD   = STAGE_MEASUREMENT_LOADING,
    ST_GROW   = STAGE_GROW,
    ST_MERGE  = STAGE_MERGE,
    ST_PEEL   = STAGE_PEELING,
    ST_RESULT = STAGE_RESULT_VALID
  } state_t;

  localparam int CNT_LIMIT = (MAX_MERGE_CYCLES > GROW_CYCLES) ? MAX_MERGE_CYCLES : GROW_CYCLES;
  localparam int CNT_W     = $clog2(CNT_LIMIT + 1);

  localparam logic [CNT_W-1:0]      GROW_LAST  = CNT_W'(GROW_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SETTLE_CNT = CNT_W'(STATUS_LATENCY);
  localparam logic [CNT_W-1:0]      WDOG_LAST  = CNT_W'(MAX_MERGE_CYCLES - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_ITERATIONS);

  state_t           state, state_next;
  logic [CNT_W-1:0] stage_cnt;
  logic             busy_any, odd_any, peel_all;
  logic             accept, set_error, settled;

  pe_status_reducer #(.PU_COUNT(PU_COUNT)) u_reducer (
    .clk                 (clk),
    .reset               (reset),
    .pe_busy             (pe_busy),
    .pe_odd              (pe_odd),
    .pe_peeling_complete (pe_peeling_complete),
    .busy_any            (busy_any),
    .odd_any             (odd_any),
    .peel_all            (peel_all)
  );

  assign global_stage = state;
  assign settled      = (stage_cnt >= SETTLE_CNT);

  // Next-state and per-cycle decisions; status is only trusted once the settle window has passed.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_next = state;
    accept     = 1'b0;
    set_error  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (meas_valid && meas_ready) begin
          accept     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: state_next = ST_GROW;
      ST_GROW: begin
        if (stage_cnt == GROW_LAST) state_next = ST_MERGE;
      end
      ST_MERGE: begin
        if (settled && !busy_any) begin
          if (!odd_any) begin
            state_next = ST_PEEL;
          end else if (iteration_count >= ITER_LIMIT) begin
            set_error  = 1'b1;
            state_next = ST_PEEL;
          end else begin
            state_next = ST_GROW;
          end
        end else if (stage_cnt == WDOG_LAST) begin
          set_error  = 1'b1;
          state_next = ST_PEEL;
        end
      end
      ST_PEEL: begin
        if (settled && peel_all) begin
          state_next = ST_RESULT;
        end else if (stage_cnt == WDOG_LAST) begin
          set_error  = 1'b1;
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (result_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, stage-local counter, iteration/error bookkeeping and registered handshakes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= ST_IDLE;
      stage_cnt       <= '0;
      iteration_count <= '0;
      decode_error    <= 1'b0;
      meas_ready      <= 1'b1;
      result_valid    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)  stage_cnt <= '0;
      else if (stage_cnt != '1) stage_cnt <= stage_cnt + CNT_W'(1);
      if (accept) begin
        iteration_count <= '0;
      end else if (state_next == ST_GROW && state != ST_GROW && iteration_count != '1) begin
        iteration_count <= iteration_count + ITER_WIDTH'(1);
      end
      if (accept)         decode_error <= 1'b0;
      else if (set_error) decode_error <= 1'b1;
      meas_ready   <= (state_next == ST_IDLE);
      result_valid <= (state_next == ST_RESULT);
    end
  end

`ifdef DECODE_CYCLE_COUNTER_EN
  // Cycles from LOAD entry through RESULT entry; starts at 1 so the LOAD cycle itself is counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      decode_cycles <= '0;
    end else if (accept) begin
      decode_cycles <= 32'd1;
    end else if (state inside {ST_LOAD, ST_GROW, ST_MERGE, ST_PEEL} && decode_cycles != '1) begin
      decode_cycles <= decode_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoding_stage_controller.sv
// Directed bench for decoding_stage_controller: stage traces are run-length
// encoded as "stage:cycles " and compared against hand-derived strings.
module tb_decoding_stage_controller;
  import decoding_stage_controller_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   meas_valid;
  logic                   meas_ready;
  logic [63:0]            pe_busy, pe_odd, pe_peeling_complete;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   result_valid;
  logic                   result_ready;
  logic [7:0]             iteration_count;
  logic                   decode_error;
`ifdef DECODE_CYCLE_COUNTER_EN
  logic [31:0]            decode_cycles;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [STAGE_WIDTH-1:0] trace[$];
  bit timed_out;

  decoding_stage_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .meas_valid          (meas_valid),
    .meas_ready          (meas_ready),
    .pe_busy             (pe_busy),
    .pe_odd              (pe_odd),
    .pe_peeling_complete (pe_peeling_complete),
    .global_stage        (global_stage),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .iteration_count     (iteration_count),
    .decode_error        (decode_error)
`ifdef DECODE_CYCLE_COUNTER_EN
    ,
    .decode_cycles       (decode_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string runs_str();
    string s = "";
    int    len = 0;
    for (int i = 0; i < trace.size(); i++) begin
      len++;
      if (i == trace.size() - 1 || trace[i+1] != trace[i]) begin
        s   = {s, $sformatf("%0d:%0d ", trace[i], len)};
        len = 0;
      end
    end
    return s;
  endfunction

  // Records one stage sample per cycle until stop_stage is seen; mode adds per-scenario stimulus.
  task automatic collect(input int budget, input int mode, input logic [STAGE_WIDTH-1:0] stop_stage);
    int grow_runs = 0;
    int merge_idx = 0;
    int peel_idx  = 0;
    logic [STAGE_WIDTH-1:0] prev = '1;
    trace.delete();
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      trace.push_back(global_stage);
      if (mode == 3) begin
        if (global_stage == STAGE_GROW && prev != STAGE_GROW) grow_runs++;
        if (grow_runs == 2) pe_odd = '0;
      end
      if (mode == 4) begin
        if (global_stage == STAGE_MERGE) begin
          if (merge_idx == 12) pe_busy = '0;
          merge_idx++;
        end
        if (global_stage == STAGE_PEELING) begin
          if (peel_idx == 5) pe_peeling_complete = '1;
          peel_idx++;
        end
      end
      if (global_stage == stop_stage) begin
        timed_out = 1'b0;
        break;
      end
      prev = global_stage;
      step();
    end
  endtask

  task automatic start_round();
    meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
  endtask

  task automatic accept_result();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; meas_valid = 1'b1; result_ready = 1'b0;
    pe_busy = '0; pe_odd = '0; pe_peeling_complete = '1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (global_stage !== STAGE_IDLE) begin
        tests_failed++; $display("FAIL reset_stage cyc%0d got=%0d exp=%0d", c, global_stage, STAGE_IDLE);
      end
      tests_run++;
      if (meas_ready !== 1'b1) begin
        tests_failed++; $display("FAIL reset_meas_ready cyc%0d got=%b exp=1", c, meas_ready);
      end
      tests_run++;
      if (result_valid !== 1'b0) begin
        tests_failed++; $display("FAIL reset_result_valid cyc%0d got=%b exp=0", c, result_valid);
      end
    end
    meas_valid = 1'b0;
    reset = 1'b1;
    step();
    tests_run++;
    if (global_stage !== STAGE_IDLE || iteration_count !== 8'd0 || decode_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release got stage=%0d iter=%0d err=%b exp stage=0 iter=0 err=0",
               global_stage, iteration_count, decode_error);
    end
  endtask

  task automatic test_no_errors();
    string got;
    pe_odd = '0; pe_busy = '0; pe_peeling_complete = '1;
    start_round();
    tests_run++;
    if (meas_ready !== 1'b0) begin
      tests_failed++; $display("FAIL noerr_meas_ready_busy got=%b exp=0", meas_ready);
    end
    collect(100, 0, STAGE_RESULT_VALID);
    got = runs_str();
    tests_run++;
    if (timed_out) begin
      tests_failed++; $display("FAIL noerr_timeout got=no RESULT exp=RESULT within 100 cycles");
    end
    tests_run++;
    if (got != "1:1 2:2 3:4 4:4 5:1 ") begin
      tests_failed++; $display("FAIL noerr_trace got=%s exp=1:1 2:2 3:4 4:4 5:1", got);
    end
    tests_run++;
    if (iteration_count !== 8'd1 || decode_error !== 1'b0 || result_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL noerr_status got iter=%0d err=%b rv=%b exp iter=1 err=0 rv=1",
               iteration_count, decode_error, result_valid);
    end
`ifdef DECODE_CYCLE_COUNTER_EN
    tests_run++;
    if (decode_cycles !== 32'd12) begin
      tests_failed++; $display("FAIL noerr_decode_cycles got=%0d exp=12", decode_cycles);
    end
`endif
    accept_result();
    tests_run++;
    if (global_stage !== STAGE_IDLE || result_valid !== 1'b0 || meas_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL noerr_accept got stage=%0d rv=%b mr=%b exp stage=0 rv=0 mr=1",
               global_stage, result_valid, meas_ready);
    end
`ifdef DECODE_CYCLE_COUNTER_EN
    tests_run++;
    if (decode_cycles !== 32'd12) begin
      tests_failed++; $display("FAIL noerr_decode_cycles_frozen got=%0d exp=12", decode_cycles);
    end
`endif
  endtask

  task automatic test_two_iterations();
    string got;
    pe_odd = 64'h1 << 63; pe_busy = '0; pe_peeling_complete = '1;
    step();
    start_round();
    meas_valid = 1'b1;   // held high mid-round: must be ignored
    collect(100, 3, STAGE_RESULT_VALID);
    meas_valid = 1'b0;
    got = runs_str();
    tests_run++;
    if (got != "1:1 2:2 3:4 2:2 3:4 4:4 5:1 ") begin
      tests_failed++; $display("FAIL iter2_trace got=%s exp=1:1 2:2 3:4 2:2 3:4 4:4 5:1", got);
    end
    tests_run++;
    if (iteration_count !== 8'd2 || decode_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL iter2_status got iter=%0d err=%b exp iter=2 err=0", iteration_count, decode_error);
    end
    accept_result();
  endtask

  task automatic test_merge_busy();
    string got;
    pe_odd = '0; pe_busy = 64'h1 << 37; pe_peeling_complete = ~64'h1;
    step();
    start_round();
    collect(100, 4, STAGE_RESULT_VALID);
    got = runs_str();
    tests_run++;
    if (got != "1:1 2:2 3:14 4:7 5:1 ") begin
      tests_failed++; $display("FAIL busy_trace got=%s exp=1:1 2:2 3:14 4:7 5:1", got);
    end
    tests_run++;
    if (decode_error !== 1'b0) begin
      tests_failed++; $display("FAIL busy_error got=%b exp=0", decode_error);
    end
    accept_result();
  endtask

  task automatic test_limits();
    string got, exp;
    pe_odd = 64'h1 << 10; pe_busy = '0; pe_peeling_complete = '1;
    step();
    start_round();
    collect(400, 0, STAGE_RESULT_VALID);
    got = runs_str();
    exp = "1:1 ";
    for (int k = 0; k < 16; k++) exp = {exp, "2:2 3:4 "};
    exp = {exp, "4:4 5:1 "};
    tests_run++;
    if (got != exp) begin
      tests_failed++; $display("FAIL iterlimit_trace got=%s exp=%s", got, exp);
    end
    tests_run++;
    if (iteration_count !== 8'd16 || decode_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL iterlimit_status got iter=%0d err=%b exp iter=16 err=1", iteration_count, decode_error);
    end
    accept_result();
    pe_odd = '0; pe_busy = 64'h1 << 3;
    step();
    start_round();
    tests_run++;
    if (decode_error !== 1'b0 || iteration_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL error_clear_on_accept got err=%b iter=%0d exp err=0 iter=0", decode_error, iteration_count);
    end
    collect(600, 0, STAGE_RESULT_VALID);
    got = runs_str();
    tests_run++;
    if (got != "1:1 2:2 3:255 4:4 5:1 ") begin
      tests_failed++; $display("FAIL watchdog_trace got=%s exp=1:1 2:2 3:255 4:4 5:1", got);
    end
    tests_run++;
    if (decode_error !== 1'b1 || iteration_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL watchdog_status got err=%b iter=%0d exp err=1 iter=1", decode_error, iteration_count);
    end
    accept_result();
    pe_busy = '0;
  endtask

  task automatic test_backpressure();
    pe_odd = '0; pe_busy = '0; pe_peeling_complete = '1;
    step();
    start_round();
    collect(100, 0, STAGE_RESULT_VALID);
    tests_run++;
    if (timed_out) begin
      tests_failed++; $display("FAIL bp_timeout got=no RESULT exp=RESULT within 100 cycles");
    end
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (result_valid !== 1'b1 || global_stage !== STAGE_RESULT_VALID) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d got rv=%b stage=%0d exp rv=1 stage=5", c, result_valid, global_stage);
      end
    end
    accept_result();
    tests_run++;
    if (result_valid !== 1'b0 || global_stage !== STAGE_IDLE) begin
      tests_failed++;
      $display("FAIL bp_release got rv=%b stage=%0d exp rv=0 stage=0", result_valid, global_stage);
    end
  endtask

  task automatic test_abort();
    string got;
    pe_odd = '0; pe_busy = '0; pe_peeling_complete = '1;
    result_ready = 1'b1;   // outside RESULT: must be ignored
    start_round();
    collect(50, 0, STAGE_MERGE);
    got = runs_str();
    tests_run++;
    if (got != "1:1 2:2 3:1 ") begin
      tests_failed++; $display("FAIL abort_trace got=%s exp=1:1 2:2 3:1", got);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (global_stage !== STAGE_IDLE || meas_ready !== 1'b1 || result_valid !== 1'b0 ||
        iteration_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL abort_reset got stage=%0d mr=%b rv=%b iter=%0d exp stage=0 mr=1 rv=0 iter=0",
               global_stage, meas_ready, result_valid, iteration_count);
    end
    reset = 1'b1;
    result_ready = 1'b0;
    step();
    step();
    tests_run++;
    if (global_stage !== STAGE_IDLE || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_result got stage=%0d rv=%b exp stage=0 rv=0", global_stage, result_valid);
    end
  endtask

  initial begin
    test_reset();
    test_no_errors();
    test_two_iterations();
    test_merge_busy();
    test_limits();
    test_backpressure();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
